// File: rtl/adc_sample_monitor.sv
// ADC sample monitor: sliding boxcar average over 2^AVG_LOG2 samples,
// in-range window check and sticky fault after consecutive excursions.
module adc_sample_monitor #(
  parameter int          AVG_LOG2    = 3,
  parameter int          FAULT_COUNT = 4,
  parameter logic [11:0] LOW_TH      = 12'd500,
  parameter logic [11:0] HIGH_TH     = 12'd3500
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [11:0] sample_in,
  input  logic        sample_valid,
  input  logic        fault_clr,
  output logic [11:0] avg_out,
  output logic        avg_valid,
  output logic        in_range,
  output logic        fault,
  output logic [3:0]  oor_count
);

  localparam int DEPTH  = 1 << AVG_LOG2;
  localparam int SW     = 12 + AVG_LOG2;
  localparam int PTR_W  = AVG_LOG2;
  localparam int FILL_W = AVG_LOG2 + 1;

  localparam logic [PTR_W-1:0]  PTR_ONE   = PTR_W'(1);
  localparam logic [FILL_W-1:0] FILL_ONE  = FILL_W'(1);
  localparam logic [FILL_W-1:0] FILL_LAST = FILL_W'(DEPTH - 1);
  localparam logic [3:0]        OOR_MAX   = 4'(FAULT_COUNT);

  localparam logic [1:0] S_FILL  = 2'd0;
  localparam logic [1:0] S_RUN   = 2'd1;
  localparam logic [1:0] S_FAULT = 2'd2;

  logic [11:0]       mem_q [DEPTH];
  logic [PTR_W-1:0]  wptr_q, wptr_d;
  logic [FILL_W-1:0] fill_q, fill_d;
  logic [SW-1:0]     sum_q, sum_d;
  logic [1:0]        state_q, state_d;
  logic [11:0]       avg_q, avg_d;
  logic              avg_valid_q, avg_valid_d;
  logic              in_range_q, in_range_d;
  logic              fault_q, fault_d;
  logic [3:0]        oor_q, oor_d;

  logic [11:0] oldest;
  logic        produce;
  logic        in_win;

  assign oldest = mem_q[wptr_q];

  // Window bookkeeping: running sum, pointer, fill count, new average.
  always_comb begin
    sum_d       = sum_q;
    wptr_d      = wptr_q;
    fill_d      = fill_q;
    avg_d       = avg_q;
    avg_valid_d = 1'b0;
    produce     = 1'b0;
    if (sample_valid) begin
      sum_d  = sum_q + SW'(sample_in) - SW'(oldest);
      wptr_d = wptr_q + PTR_ONE;
      if (state_q == S_FILL) begin
        fill_d  = fill_q + FILL_ONE;
        produce = (fill_q == FILL_LAST);
      end else begin
        produce = 1'b1;
      end
    end
    if (produce) begin
      avg_d       = sum_d[AVG_LOG2 +: 12];
      avg_valid_d = 1'b1;
    end
  end

  assign in_win = (avg_d >= LOW_TH) && (avg_d <= HIGH_TH);

  // Range check, consecutive excursion count and fault state machine.
  always_comb begin
    state_d    = state_q;
    in_range_d = in_range_q;
    oor_d      = oor_q;
    fault_d    = fault_q;
    if (produce) begin
      in_range_d = in_win;
      if (state_q == S_FILL) begin
        state_d = S_RUN;
      end
      if (in_win) begin
        oor_d = 4'd0;
      end else if (oor_q != OOR_MAX) begin
        oor_d = oor_q + 4'd1;
      end
      if (!in_win && oor_d == OOR_MAX) begin
        fault_d = 1'b1;
        state_d = S_FAULT;
      end
    end
    // A clear beats a coincident excursion: that average is not counted.
    if (state_q == S_FAULT && fault_clr) begin
      fault_d = 1'b0;
      oor_d   = 4'd0;
      state_d = S_RUN;
    end
  end

  // Sample history; reset wipes it so no stale samples reach a new window.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= 12'd0;
      end
    end else if (sample_valid) begin
      mem_q[wptr_q] <= sample_in;
    end
  end

  // Datapath and status registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      wptr_q      <= '0;
      fill_q      <= '0;
      sum_q       <= '0;
      state_q     <= S_FILL;
      avg_q       <= 12'd0;
      avg_valid_q <= 1'b0;
      in_range_q  <= 1'b1;
      fault_q     <= 1'b0;
      oor_q       <= 4'd0;
    end else begin
      wptr_q      <= wptr_d;
      fill_q      <= fill_d;
      sum_q       <= sum_d;
      state_q     <= state_d;
      avg_q       <= avg_d;
      avg_valid_q <= avg_valid_d;
      in_range_q  <= in_range_d;
      fault_q     <= fault_d;
      oor_q       <= oor_d;
    end
  end

  assign avg_out   = avg_q;
  assign avg_valid = avg_valid_q;
  assign in_range  = in_range_q;
  assign fault     = fault_q;
  assign oor_count = oor_q;

endmodule

// File: tb/tb_adc_sample_monitor.sv
// Directed testbench for adc_sample_monitor with
// hand-computed expected values and immediate assertions.
module tb_adc_sample_monitor;

  logic        clk;
  logic        rst;
  logic [11:0] sample_in;
  logic        sample_valid;
  logic        fault_clr;
  logic [11:0] avg_out;
  logic        avg_valid;
  logic        in_range;
  logic        fault;
  logic [3:0]  oor_count;

  int n_checks = 0;
  int n_fail   = 0;

  localparam logic [1:0] ST_FILL  = 2'd0;
  localparam logic [1:0] ST_RUN   = 2'd1;
  localparam logic [1:0] ST_FAULT = 2'd2;

  adc_sample_monitor dut (
    .clk          (clk),
    .rst          (rst),
    .sample_in    (sample_in),
    .sample_valid (sample_valid),
    .fault_clr    (fault_clr),
    .avg_out      (avg_out),
    .avg_valid    (avg_valid),
    .in_range     (in_range),
    .fault        (fault),
    .oor_count    (oor_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic chk_avg(input string tag, input int a, input int r,
                         input int o, input int f);
    chk({tag, ".valid"}, 32'(avg_valid), 32'd1);
    chk({tag, ".avg"}, 32'(avg_out), 32'(a));
    chk({tag, ".in_range"}, 32'(in_range), 32'(r));
    chk({tag, ".oor"}, 32'(oor_count), 32'(o));
    chk({tag, ".fault"}, 32'(fault), 32'(f));
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, ".avg"}, 32'(avg_out), 32'd0);
    chk({tag, ".valid"}, 32'(avg_valid), 32'd0);
    chk({tag, ".in_range"}, 32'(in_range), 32'd1);
    chk({tag, ".fault"}, 32'(fault), 32'd0);
    chk({tag, ".oor"}, 32'(oor_count), 32'd0);
    chk({tag, ".state"}, 32'(dut.state_q), 32'(ST_FILL));
  endtask

  task automatic strobe(input logic [11:0] v, input logic clr);
    @(negedge clk);
    sample_in    = v;
    sample_valid = 1'b1;
    fault_clr    = clr;
    @(negedge clk);
    sample_valid = 1'b0;
    fault_clr    = 1'b0;
  endtask

  task automatic do_reset(input logic with_sample);
    @(negedge clk);
    rst          = 1'b1;
    sample_in    = 12'd4000;
    sample_valid = with_sample;
    @(negedge clk);
    rst          = 1'b0;
    sample_valid = 1'b0;
  endtask

  task automatic chk_b2b(input int k);
    if (k < 8) chk("b2b.no_valid", 32'(avg_valid), 32'd0);
    else chk_avg("b2b", 4000, 0, k - 7, (k == 11) ? 1 : 0);
  endtask

  int slide_exp [8] = '{2292, 2536, 2780, 3024, 3268, 3512, 3756, 4000};

  initial begin
    rst          = 1'b1;
    sample_in    = 12'd0;
    sample_valid = 1'b0;
    fault_clr    = 1'b0;
    repeat (2) @(negedge clk);
    chk_reset("por");
    rst = 1'b0;

    // Fill: 8 strobes of 2048, 3 clk apart
    for (int i = 1; i <= 8; i++) begin
      strobe(12'd2048, 1'b0);
      if (i < 8) begin
        chk("fill.no_valid", 32'(avg_valid), 32'd0);
        repeat (1) @(negedge clk);
      end
    end
    chk_avg("fill.first", 2048, 1, 0, 0);
    chk("fill.state", 32'(dut.state_q), 32'(ST_RUN));
    @(negedge clk);
    chk("fill.pulse", 32'(avg_valid), 32'd0);

    // Sliding toward 4000
    for (int i = 0; i < 8; i++) begin
      strobe(12'd4000, 1'b0);
      chk_avg("slide", slide_exp[i], (i < 5) ? 1 : 0,
              (i < 5) ? 0 : i - 4, 0);
    end

    // Fault: 11 back-to-back strobes of 4000
    do_reset(1'b0);
    for (int i = 1; i <= 11; i++) begin
      @(negedge clk);
      if (i > 1) chk_b2b(i - 1);
      sample_in    = 12'd4000;
      sample_valid = 1'b1;
    end
    @(negedge clk);
    sample_valid = 1'b0;
    chk_b2b(11);
    chk("fault.state", 32'(dut.state_q), 32'(ST_FAULT));

    // Saturation in FAULT
    strobe(12'd4000, 1'b0);
    chk_avg("fault.sat", 4000, 0, 4, 1);

    // Clear coinciding with an out-of-range average
    strobe(12'd4000, 1'b1);
    chk_avg("clr.coinc", 4000, 0, 0, 0);
    chk("clr.state", 32'(dut.state_q), 32'(ST_RUN));
    strobe(12'd4000, 1'b0);
    chk_avg("clr.recount", 4000, 0, 1, 0);

    // Clear in RUN has no effect
    @(negedge clk);
    fault_clr = 1'b1;
    @(negedge clk);
    fault_clr = 1'b0;
    chk("run_clr.oor", 32'(oor_count), 32'd1);
    chk("run_clr.fault", 32'(fault), 32'd0);
    chk("run_clr.state", 32'(dut.state_q), 32'(ST_RUN));

    // Reset from RUN, with a strobe in the reset cycle
    do_reset(1'b1);
    chk_reset("rst_run");

    // Upper threshold: 3 excursions then exactly 3500
    for (int i = 1; i <= 10; i++) strobe(12'd4000, 1'b0);
    chk_avg("hi.pre", 4000, 0, 3, 0);
    strobe(12'd0, 1'b0);
    chk_avg("hi.edge", 3500, 1, 0, 0);

    // Lower threshold: 3 excursions then exactly 500
    do_reset(1'b0);
    for (int i = 1; i <= 10; i++) strobe(12'd100, 1'b0);
    chk_avg("lo.pre", 100, 0, 3, 0);
    strobe(12'd3300, 1'b0);
    chk_avg("lo.edge", 500, 1, 0, 0);

    // Reset mid-fill
    do_reset(1'b0);
    for (int i = 1; i <= 5; i++) strobe(12'd4000, 1'b0);
    do_reset(1'b1);
    chk_reset("rst_fill");
    for (int i = 1; i <= 8; i++) begin
      strobe(12'd1000, 1'b0);
      if (i < 8) chk("refill.no_valid", 32'(avg_valid), 32'd0);
    end
    chk_avg("refill.first", 1000, 1, 0, 0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/adc_sample_monitor.md
Name: adc_sample_monitor

Overview:
- Downstream consumer of the 12-bit ADC sample stream from the ADC control stage.
- Computes a sliding boxcar average over 2^AVG_LOG2 samples and checks each average against a fixed in-range window.
- Raises a sticky fault after FAULT_COUNT consecutive out-of-range averages. This is the basic failure detector for the circuit-twinning comparison.

Parameters:
- AVG_LOG2, 3: log2 of the averaging window depth (default 8 samples). Legal range 1..5.
- FAULT_COUNT, 4: consecutive out-of-range averages required to declare a fault. Legal range 1..15.
- LOW_TH, 12'd500: lowest in-range average, inclusive.
- HIGH_TH, 12'd3500: highest in-range average, inclusive.

Ports:
- clk  input  1  system clock (50 MHz FPGA clock domain)
- rst  input  1  synchronous reset, active-high
- sample_in  input  12  completed ADC sample, unsigned
- sample_valid  input  1  one-cycle strobe in the clk domain; sample_in is valid in that cycle
- fault_clr  input  1  one-cycle request to clear the sticky fault
- avg_out  output  12  latest window average, unsigned
- avg_valid  output  1  one-cycle strobe; avg_out updated this cycle
- in_range  output  1  1 when the latest avg_out is within [LOW_TH, HIGH_TH]
- fault  output  1  sticky fault flag
- oor_count  output  4  current count of consecutive out-of-range averages, saturating at FAULT_COUNT

Behaviour:
- Reset: all outputs are 0, except in_range, which resets to 1.
  - The circular buffer, running sum, write pointer and fill counter clear to 0.
  - The state machine goes to FILL.
  - Reset at any time, including mid-fill or in FAULT, aborts everything and restarts from FILL. No sample accepted in the reset cycle is retained.
- Buffer: 2^AVG_LOG2 entries, each 12 bits; write pointer wraps modulo the depth.
- Update rule on each sample_valid:
  - oldest = buf[wptr]
  - buf[wptr] <= sample_in
  - wptr <= wptr + 1
  - sum <= sum + sample_in - oldest
  - sum is 12+AVG_LOG2 bits wide and never overflows or underflows.
- Averaging: avg_out <= (sum + sample_in - oldest) >> AVG_LOG2, truncated (floor) and registered.
  - Latency: avg_out and avg_valid appear 1 clk after the accepted sample_valid.
- sample_valid is ignored in the cycle it is sampled only while rst=1. Back-to-back strobes on consecutive cycles are each accepted.
- State machine:
  - FILL:
    - Counts accepted samples; avg_valid stays 0.
    - On the 2^AVG_LOG2-th sample, produce the first average (avg_valid=1 next cycle) and go to RUN.
  - RUN:
    - Each average is checked: in-range when LOW_TH <= avg <= HIGH_TH. Equality counts as in-range.
    - An out-of-range average increments oor_count; an in-range average clears it to 0.
    - When oor_count reaches FAULT_COUNT, set fault=1 and go to FAULT.
    - Timing: in_range, oor_count and fault update in the same cycle as avg_valid.
  - FAULT:
    - Averaging, in_range and oor_count continue updating as in RUN; fault holds at 1.
    - fault_clr=1 sets fault=0, oor_count=0 and returns to RUN.
- Simultaneous events:
  - If fault_clr coincides with an average that would increment the count, fault_clr wins: fault=0, oor_count=0, and that average is not counted.
  - fault_clr in FILL or RUN has no effect.
- oor_count saturates at FAULT_COUNT and never wraps.

Test Plan:
- Fill: after rst, apply 8 strobes with sample_in=2048, 3 clk apart.
  - Required: avg_valid stays 0 for strobes 1-7.
  - Required: avg_valid=1 with avg_out=2048, in_range=1 one clk after strobe 8, and the state moves to RUN.
- Sliding: continuing from the fill scenario, apply one strobe with 4000.
  - Required: avg_out = (7*2048+4000)>>3 = 2292.
  - Apply seven more strobes of 4000; required: the 8th average is 4000 and in_range=0.
- Fault: after rst, apply 11 strobes of 4000, back-to-back.
  - Required: the first average follows the 8th strobe.
  - Required: oor_count reads 1, 2, 3, 4 on the averages after strobes 8-11, and fault rises together with the average after strobe 11.
- Count reset and thresholds:
  - In RUN, apply 3 out-of-range averages, then an average of exactly 3500; required: in_range=1 and oor_count=0, with no fault.
  - Repeat with an average of exactly 500; required: the same result.
- Clear: in FAULT, assert fault_clr together with an out-of-range average.
  - Required: fault=0 and oor_count=0 next cycle, and the state is RUN.
  - Assert fault_clr in RUN; required: no change.
- Reset mid-operation: assert rst after 5 fill strobes.
  - Required: all outputs return to reset values.
  - Required: the first average appears only after 8 new strobes, and its value excludes the pre-reset samples.
